// File: rtl/apple1_pkg.sv
// Shared types and constants for the Apple-1 program loader slice.
package apple1_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HDR_LO = 3'd1,
        HDR_HI = 3'd2,
        DATA   = 3'd3,
        FINISH = 3'd4,
        ERR    = 3'd5
    } prg_state_t;

    // 6502 reset vector location, served by the top level after a CPU restart.
    localparam logic [15:0] RESET_VEC_LO = 16'hFFFC;
    localparam logic [15:0] RESET_VEC_HI = 16'hFFFD;

    // True when a payload address falls inside writable RAM.
    function automatic logic addr_writable(input logic [15:0] addr, input logic [15:0] top);
        return (addr <= top);
    endfunction

endpackage

// File: rtl/prg_autorun.sv
// CPU restart sequencer: holds cpu_rst_req for RST_HOLD cycles after a clean
// load, then offers the load address as the reset vector until acknowledged.
// Only instantiated when PRG_AUTORUN_EN is defined.
module prg_autorun #(
    parameter int RST_HOLD = 16
) (
    input  logic        clk14,
    input  logic        rst_n,
    input  logic        start,
    input  logic        done,
    input  logic        dropped,
    input  logic [15:0] load_start,
    input  logic        vec_ack,
    output logic        cpu_rst_req,
    output logic        vec_valid,
    output logic [15:0] vec_addr
);

    localparam logic [15:0] HOLD_LAST = 16'(RST_HOLD - 1);

    logic [15:0] cnt_r;
    logic        req_r;
    logic        valid_r;
    logic [15:0] addr_r;

    // Reset-hold countdown followed by the vector handshake.
    always_ff @(posedge clk14 or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= 16'd0;
            req_r   <= 1'b0;
            valid_r <= 1'b0;
            addr_r  <= 16'd0;
        end else if (start) begin
            cnt_r   <= 16'd0;
            req_r   <= 1'b0;
            valid_r <= 1'b0;
        end else if (done && !dropped) begin
            cnt_r   <= HOLD_LAST;
            req_r   <= 1'b1;
            valid_r <= 1'b0;
        end else if (req_r) begin
            if (cnt_r == 16'd0) begin
                req_r   <= 1'b0;
                valid_r <= 1'b1;
                addr_r  <= load_start;
            end else begin
                cnt_r <= cnt_r - 16'd1;
            end
        end else if (valid_r && vec_ack) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign cpu_rst_req = req_r;
    assign vec_valid   = valid_r;
    assign vec_addr    = addr_r;

endmodule

// File: rtl/prg_loader.sv
// Apple-1 ".prg" loader: strips the 2-byte little-endian load address from
// the downloader stream and writes the payload into RAM at load_addr+n.
// Optional CPU autorun is enabled with the PRG_AUTORUN_EN macro.
module prg_loader
    import apple1_pkg::*;
#(
    parameter logic [7:0]  PRG_INDEX = 8'd1,
    parameter logic [15:0] RAM_TOP   = 16'h1FFF
`ifdef PRG_AUTORUN_EN
    ,
    parameter int          RST_HOLD  = 16
`endif
) (
    input  logic        clk14,
    input  logic        rst_n,
    input  logic        dl_active,
    input  logic [7:0]  dl_index,
    input  logic        dl_wr,
    input  logic [7:0]  dl_data,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_din,
    output logic        mem_wr,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        dropped,
    output logic [15:0] load_start,
    output logic [15:0] load_end
`ifdef PRG_AUTORUN_EN
    ,
    output logic        cpu_rst_req,
    output logic        vec_valid,
    output logic [15:0] vec_addr,
    input  logic        vec_ack
`endif
);

    prg_state_t  state_r, state_nxt;
    logic        active_q_r;
    logic        accept_s;
    logic        take_s;

    logic [7:0]  hdr_lo_r, hdr_lo_nxt;
    logic [15:0] ptr_r, ptr_nxt;
    logic [15:0] mem_addr_r, mem_addr_nxt;
    logic [7:0]  mem_din_r, mem_din_nxt;
    logic        mem_wr_r, mem_wr_nxt;
    logic        busy_r, busy_nxt;
    logic        done_r, done_nxt;
    logic        error_r, error_nxt;
    logic        dropped_r, dropped_nxt;
    logic [15:0] load_start_r, load_start_nxt;
    logic [15:0] load_end_r, load_end_nxt;

    // A transfer starts on the rising edge of dl_active with our menu index.
    assign accept_s = dl_active && !active_q_r && (dl_index == PRG_INDEX) && (state_r == IDLE);
    // Strobes count while active, including the cycle in which dl_active falls.
    assign take_s   = dl_wr && (dl_active || active_q_r);

    // State register and dl_active edge history.
    always_ff @(posedge clk14 or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            active_q_r <= 1'b0;
        end else begin
            state_r    <= state_nxt;
            active_q_r <= dl_active;
        end
    end

    // Next-state logic; a byte arriving with the fall is consumed before the exit.
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_nxt = HDR_LO;
                else          state_nxt = IDLE;
            end
            HDR_LO: begin
                if (!dl_active)  state_nxt = ERR;
                else if (take_s) state_nxt = HDR_HI;
                else             state_nxt = HDR_LO;
            end
            HDR_HI: begin
                if (!dl_active)  state_nxt = take_s ? FINISH : ERR;
                else if (take_s) state_nxt = DATA;
                else             state_nxt = HDR_HI;
            end
            DATA: begin
                if (!dl_active) state_nxt = FINISH;
                else            state_nxt = DATA;
            end
            FINISH:  state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath / output next values for the current state.
    always_comb begin
        hdr_lo_nxt     = hdr_lo_r;
        ptr_nxt        = ptr_r;
        mem_addr_nxt   = mem_addr_r;
        mem_din_nxt    = mem_din_r;
        mem_wr_nxt     = 1'b0;
        busy_nxt       = busy_r;
        done_nxt       = 1'b0;
        error_nxt      = error_r;
        dropped_nxt    = dropped_r;
        load_start_nxt = load_start_r;
        load_end_nxt   = load_end_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    error_nxt   = 1'b0;
                    dropped_nxt = 1'b0;
                end else begin
                    error_nxt   = error_r;
                    dropped_nxt = dropped_r;
                end
            end
            HDR_LO: begin
                if (take_s) begin
                    hdr_lo_nxt = dl_data;
                    busy_nxt   = 1'b1;
                end else begin
                    hdr_lo_nxt = hdr_lo_r;
                end
            end
            HDR_HI: begin
                if (take_s) begin
                    load_start_nxt = {dl_data, hdr_lo_r};
                    ptr_nxt        = {dl_data, hdr_lo_r};
                end else begin
                    ptr_nxt = ptr_r;
                end
            end
            DATA: begin
                if (take_s) begin
                    mem_addr_nxt = ptr_r;
                    mem_din_nxt  = dl_data;
                    mem_wr_nxt   = addr_writable(ptr_r, RAM_TOP);
                    dropped_nxt  = dropped_r || !addr_writable(ptr_r, RAM_TOP);
                    ptr_nxt      = ptr_r + 16'd1;
                end else begin
                    ptr_nxt = ptr_r;
                end
            end
            FINISH: begin
                load_end_nxt = ptr_r - 16'd1;
                done_nxt     = 1'b1;
                busy_nxt     = 1'b0;
            end
            ERR: begin
                error_nxt = 1'b1;
                busy_nxt  = 1'b0;
            end
            default: begin
                busy_nxt = 1'b0;
            end
        endcase
    end

    // Registered datapath and outputs.
    always_ff @(posedge clk14 or negedge rst_n) begin
        if (!rst_n) begin
            hdr_lo_r     <= 8'd0;
            ptr_r        <= 16'd0;
            mem_addr_r   <= 16'd0;
            mem_din_r    <= 8'd0;
            mem_wr_r     <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
            dropped_r    <= 1'b0;
            load_start_r <= 16'd0;
            load_end_r   <= 16'd0;
        end else begin
            hdr_lo_r     <= hdr_lo_nxt;
            ptr_r        <= ptr_nxt;
            mem_addr_r   <= mem_addr_nxt;
            mem_din_r    <= mem_din_nxt;
            mem_wr_r     <= mem_wr_nxt;
            busy_r       <= busy_nxt;
            done_r       <= done_nxt;
            error_r      <= error_nxt;
            dropped_r    <= dropped_nxt;
            load_start_r <= load_start_nxt;
            load_end_r   <= load_end_nxt;
        end
    end

    assign mem_addr   = mem_addr_r;
    assign mem_din    = mem_din_r;
    assign mem_wr     = mem_wr_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign error      = error_r;
    assign dropped    = dropped_r;
    assign load_start = load_start_r;
    assign load_end   = load_end_r;

`ifdef PRG_AUTORUN_EN
    prg_autorun #(
        .RST_HOLD (RST_HOLD)
    ) u_autorun (
        .clk14       (clk14),
        .rst_n       (rst_n),
        .start       (accept_s),
        .done        (done_r),
        .dropped     (dropped_r),
        .load_start  (load_start_r),
        .vec_ack     (vec_ack),
        .cpu_rst_req (cpu_rst_req),
        .vec_valid   (vec_valid),
        .vec_addr    (vec_addr)
    );
`endif

endmodule

// File: doc/prg_loader.md
Name: prg_loader

Overview:
- Sits between the SPI downloader and the RAM write mux of the Apple-1 top level.
- Consumes the downloader byte stream for the ".prg" menu index.
- Strips the 2-byte little-endian load-address header, then emits one RAM write per payload byte at load_addr+n, masking writes outside RAM.
- Reports busy, done, error and load range to the top level; optionally requests a CPU restart into the loaded program.

Parameters:
- PRG_INDEX, 1, downloader menu index this block responds to.
- RAM_TOP, 16'h1FFF, highest writable address; payload bytes above it are dropped, not written.
- RST_HOLD, 16, cycles cpu_rst_req is held (optional feature only).

Ports:
- clk14  in  1  system clock, 14.31818 MHz.
- rst_n  in  1  asynchronous active-low reset.
- dl_active  in  1  downloader transfer in progress.
- dl_index  in  8  menu index of the current transfer.
- dl_wr  in  1  one-cycle strobe, dl_data valid.
- dl_data  in  8  download byte.
- mem_addr  out  16  RAM write address.
- mem_din  out  8  RAM write data.
- mem_wr  out  1  one-cycle RAM write strobe.
- busy  out  1  high from first header byte until FINISH completes.
- done  out  1  one-cycle pulse on successful load end.
- error  out  1  sticky: transfer ended with fewer than 2 bytes; cleared at next accepted start.
- dropped  out  1  sticky: at least one payload byte exceeded RAM_TOP; cleared at next accepted start.
- load_start  out  16  header address of the last load.
- load_end  out  16  address of the last byte written (inclusive).

Behaviour:
- Reset value: every output is 0. The FSM enters IDLE. Reset mid-load abandons the load with no done or error, and no further writes.
- A transfer is accepted when dl_active rises while dl_index==PRG_INDEX. Any other index is ignored entirely, and its strobes produce no mem_wr.
- States:
  - IDLE: on accepted start, clear error/dropped and go to HDR_LO.
  - HDR_LO: on dl_wr, latch the low byte and go to HDR_HI. If dl_active falls, go to ERR.
  - HDR_HI: on dl_wr, latch the high byte, set load_start and the internal pointer ptr, and go to DATA. If dl_active falls, go to ERR.
  - DATA: on each dl_wr, register mem_addr=ptr, mem_din=dl_data, mem_wr=(ptr<=RAM_TOP), then ptr=ptr+1. When mem_wr is suppressed, set dropped. When dl_active falls, go to FINISH.
  - FINISH: load_end=ptr-1, pulse done, busy=0, go to IDLE. With zero payload bytes, load_end=load_start-1 (mod 2^16) and done still pulses.
  - ERR: set error, busy=0, go to IDLE. No done pulse.
- Latency: mem_wr is asserted exactly 1 cycle after the dl_wr that carried the byte; mem_wr is never held for 2 or more cycles.
- ptr is 16-bit and wraps from FFFF to 0000. After the wrap it is writable again if <=RAM_TOP.
- dl_wr in the same cycle dl_active falls: the byte is processed first, then the state transition applies.
- dl_wr outside dl_active is ignored.
- Back-to-back dl_wr on consecutive cycles must be sustained.

Optional Feature:
- Macro: PRG_AUTORUN_EN.
- Defined: adds ports cpu_rst_req out 1, vec_valid out 1, vec_addr out 16, vec_ack in 1.
  - On done, assert cpu_rst_req for RST_HOLD cycles.
  - When the hold ends, assert vec_valid with vec_addr=load_start, held until vec_ack (the top level asserts it once the CPU reset-vector fetch at FFFC/FFFD is served).
  - A new accepted start clears vec_valid.
  - Autorun is suppressed when dropped is set.
- Undefined: these ports are absent; done is the only completion indication.

Decomposition:
- Package apple1_pkg holds:
  - the state enum prg_state_t (IDLE, HDR_LO, HDR_HI, DATA, FINISH, ERR);
  - constants RESET_VEC_LO=16'hFFFC and RESET_VEC_HI=16'hFFFD.
- No sub-module for the core. Under PRG_AUTORUN_EN, a small sub-module prg_autorun holds the reset-hold counter and the vector handshake.

Test Plan:
- Index 1, bytes 00 03 A9 01 60 -> writes 0300=A9, 0301=01, 0302=60, each 1 cycle after its dl_wr; load_start=0300, load_end=0302; done pulses once.
- Index 2, same bytes -> no mem_wr, busy stays 0, no done.
- Index 1, bytes FE 1F 11 22 33 -> writes 1FFE, 1FFF; third byte not written; dropped=1; load_end=2000; done pulses.
- Index 1, single byte 00 then dl_active falls -> error=1, no mem_wr, no done. Next valid load clears error.
- Index 1, header FF FF then 3 payload bytes -> FFFF suppressed; 0000 and 0001 written; ptr wrap verified.
- rst_n low during DATA after 2 payload bytes -> outputs 0 immediately, no done. With PRG_AUTORUN_EN: a normal load to 0300 holds cpu_rst_req 16 cycles, then vec_valid with vec_addr=0300 until vec_ack.
